vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/sync_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 75 +++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster-timing types, default 640x480@60 constants and helpers for the TinyVGA tiles.
package vga_timing_pkg;

    localparam int POS_W     = 10;
    localparam int POS_LIMIT = 1 << POS_W;

    typedef struct packed {
        int display;
        int front;
        int sync;
        int back;
    } vga_timing_t;

    localparam vga_timing_t VGA_H_DEFAULT = '{display: 640, front: 16, sync: 96, back: 48};
    localparam vga_timing_t VGA_V_DEFAULT = '{display: 480, front: 10, sync: 2,  back: 33};

    function automatic int calc_total(input vga_timing_t t);
        return t.display + t.front + t.sync + t.back;
    endfunction

    function automatic bit timing_ok(input vga_timing_t t);
        return (t.display > 0) && (t.front > 0) && (t.sync > 0) && (t.back > 0)
            && (calc_total(t) <= POS_LIMIT);
    endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active/at_end flags decoded from the
// next position, so the flags line up with the position presented in the same cycle.
module sync_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter bit POL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [POS_W-1:0] pos,
    output logic             sync,
    output logic             active,
    output logic             at_end
);

    localparam vga_timing_t CFG   = '{display: DISPLAY, front: FRONT, sync: SYNC, back: BACK};
    localparam int          TOTAL = calc_total(CFG);

    localparam logic [POS_W-1:0] LAST       = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] DISP_END   = POS_W'(DISPLAY);
    localparam logic [POS_W-1:0] SYNC_START = POS_W'(DISPLAY + FRONT);
    localparam logic [POS_W-1:0] SYNC_END   = POS_W'(DISPLAY + FRONT + SYNC);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             sync_q, sync_d;
    logic             active_q, active_d;
    logic             at_end_q, at_end_d;

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        pos_d = pos_q;
        if (inc) begin
            pos_d = at_end_q ? '0 : pos_q + 1'b1;
        end
        sync_d   = ((pos_d >= SYNC_START) && (pos_d < SYNC_END)) ? POL : ~POL;
        active_d = (pos_d < DISP_END);
        at_end_d = (pos_d == LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q    <= '0;
            sync_q   <= ~POL;
            active_q <= 1'b1;
            at_end_q <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            sync_q   <= sync_d;
            active_q <= active_d;
            at_end_q <= at_end_d;
        end
    end

    assign pos    = pos_q;
    assign sync   = sync_q;
    assign active = active_q;
    assign at_end = at_end_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: hsync/vsync/display_on, pixel coordinates, line/frame strobes and
// a frame counter, advancing one pixel per clock with ce high.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = VGA_H_DEFAULT.display,
    parameter int H_FRONT    = VGA_H_DEFAULT.front,
    parameter int H_SYNC     = VGA_H_DEFAULT.sync,
    parameter int H_BACK     = VGA_H_DEFAULT.back,
    parameter int V_DISPLAY  = VGA_V_DEFAULT.display,
    parameter int V_FRONT    = VGA_V_DEFAULT.front,
    parameter int V_SYNC     = VGA_V_DEFAULT.sync,
    parameter int V_BACK     = VGA_V_DEFAULT.back,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             line_end,
    output logic             frame_end,
    output logic [7:0]       frame_cnt
);

    localparam vga_timing_t H_CFG = '{display: H_DISPLAY, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam vga_timing_t V_CFG = '{display: V_DISPLAY, front: V_FRONT, sync: V_SYNC, back: V_BACK};

    if (!timing_ok(H_CFG) || !timing_ok(V_CFG)) begin : g_bad_timing
        $error("vga_timing_gen: every porch/sync/display must be nonzero and each total <= 1024");
    end

    logic h_active, h_at_end;
    logic v_active, v_at_end;
    logic v_inc;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    assign v_inc = ce & h_at_end;

    sync_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_SYNC_POL)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .inc(ce),
        .pos(hpos), .sync(hsync), .active(h_active), .at_end(h_at_end)
    );

    sync_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_SYNC_POL)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .inc(v_inc),
        .pos(vpos), .sync(vsync), .active(v_active), .at_end(v_at_end)
    );

    // Strobes are qualified by rst_n so a reset landing on a wrap cycle never reports that wrap.
    assign line_end   = rst_n & ce & h_at_end;
    assign frame_end  = line_end & v_at_end;
    assign display_on = h_active & v_active;

    assign frame_cnt_d = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

endmodule
